biquad_bank_sched: RTL and testbench

Time-multiplexed scheduler for the three-band equaliser filter bank. One shared signed N×N multiplier/accumulator evaluates all six biquad sections per input sample, in cascade order: low band LP→HP, mid band LP→HP, high band LP→HP. The block holds the coefficient RAM and the per-section history registers. It sequences the MAC taps and presents the three band outputs with a valid pulse. It replaces six parallel filter instances in front of the band-gain stage.

---
 rtl/eq_pkg.sv | 45 ++++
 rtl/biquad_mac.sv | 32 +++
 rtl/biquad_bank_sched.sv | 129 ++++++++++++
 tb/tb_biquad_bank_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: word widths, FSM encoding and default coefficient sheet
// for the three-band equaliser biquad bank.
package eq_pkg;

  localparam int DECIM    = 14;
  localparam int MAGN     = 8;
  localparam int N        = DECIM + MAGN + 1;
  localparam int ACC_W    = 2 * N + 3;
  localparam int NUM_SECT = 6;
  localparam int NUM_TAPS = 5;
  localparam int NUM_COEF = NUM_SECT * NUM_TAPS;

  typedef logic signed [N-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic signed [ACC_W-1:0] SAT_HI =
    {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO =
    {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  // b0,b1,b2,a1,a2 per section; a1/a2 already negated so all taps add
  localparam word_t COEF_DEFAULT [NUM_COEF] = '{
    23'h000040, 23'h000080, 23'h000040, 23'h007E00, 23'h7FC1C0,
    23'h003F00, 23'h7F8200, 23'h003F00, 23'h007E00, 23'h7FC1C0,
    23'h000400, 23'h000800, 23'h000400, 23'h006000, 23'h7FE800,
    23'h003000, 23'h7FA000, 23'h003000, 23'h006000, 23'h7FE800,
    23'h001800, 23'h003000, 23'h001800, 23'h002000, 23'h7FF000,
    23'h001000, 23'h7FE000, 23'h001000, 23'h002000, 23'h7FF000
  };

  function automatic word_t sat_n(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> DECIM;
    if (sh > SAT_HI) return {1'b0, {(N-1){1'b1}}};
    if (sh < SAT_LO) return {1'b1, {(N-1){1'b0}}};
    return sh[N-1:0];
  endfunction

endpackage

// File: rtl/biquad_mac.sv
// biquad_mac: shared signed multiply-accumulate with Q-format
// rescale and saturation of the section result.
module biquad_mac
  import eq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [N-1:0] i_coef,
  input  logic [N-1:0] i_x,
  output logic [N-1:0] o_y
);

  logic signed [2*N-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = $signed(i_coef) * $signed(i_x);
  assign w_base = i_clr ? '0 : r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_base + ACC_W'(w_prod);
    end
  end

  assign o_y = sat_n(r_acc);

endmodule

// File: rtl/biquad_bank_sched.sv
// biquad_bank_sched: one shared MAC walks six biquad sections per
// sample (low/mid/high band, LP then HP) and updates band outputs.
module biquad_bank_sched
  import eq_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         gen_enable,
  input  logic         sample_strobe,
  input  logic [N-1:0] dato_entrada,
  input  logic         coef_we,
  input  logic [4:0]   coef_addr,
  input  logic [N-1:0] coef_data,
  output logic [N-1:0] out_b,
  output logic [N-1:0] out_m,
  output logic [N-1:0] out_a,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun
);

  state_t       r_state, w_next;
  logic [2:0]   r_sect, r_tap;
  word_t        r_sample, r_yprev;
  word_t        r_coef [NUM_COEF];
  word_t        r_u1 [NUM_SECT];
  word_t        r_u2 [NUM_SECT];
  word_t        r_y1 [NUM_SECT];
  word_t        r_y2 [NUM_SECT];
  logic [N-1:0] r_out_b, r_out_m, r_out_a;
  logic         r_overrun;
  logic         w_start, w_mac, w_wb;
  logic [4:0]   w_caddr;
  word_t        w_u, w_x, w_y;

  assign w_start = sample_strobe && gen_enable;
  assign w_mac   = (r_state == S_MAC);
  assign w_wb    = (r_state == S_WB);
  assign w_caddr = {2'b0, r_sect} * 5'd5 + {2'b0, r_tap};
  // odd sections are the HP half of a band, fed by the LP half
  assign w_u     = r_sect[0] ? r_yprev : r_sample;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_MAC;
      S_MAC:   if (r_tap == 3'd4) w_next = S_WB;
      S_WB:    w_next = (r_sect == 3'd5) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_x = '0;
    unique case (1'b1)
      r_tap == 3'd0: w_x = w_u;
      r_tap == 3'd1: w_x = r_u1[r_sect];
      r_tap == 3'd2: w_x = r_u2[r_sect];
      r_tap == 3'd3: w_x = r_y1[r_sect];
      default:       w_x = r_y2[r_sect];
    endcase
  end

  biquad_mac u_mac (
    .clk    (clock),
    .rst_n  (reset),
    .i_clr  (r_tap == 3'd0),
    .i_en   (w_mac),
    .i_coef (r_coef[w_caddr]),
    .i_x    (w_x),
    .o_y    (w_y)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sect    <= '0;
      r_tap     <= '0;
      r_sample  <= '0;
      r_yprev   <= '0;
      r_out_b   <= '0;
      r_out_m   <= '0;
      r_out_a   <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) r_coef[i] <= COEF_DEFAULT[i];
      for (int s = 0; s < NUM_SECT; s++) begin
        r_u1[s] <= '0;
        r_u2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      if (sample_strobe && r_state != S_IDLE) r_overrun <= 1'b1;
      if (r_state == S_IDLE) begin
        if (coef_we && coef_addr < 5'(NUM_COEF)) r_coef[coef_addr] <= coef_data;
        if (w_start) begin
          r_sample <= dato_entrada;
          r_sect   <= '0;
          r_tap    <= '0;
        end
      end
      if (w_mac) r_tap <= (r_tap == 3'd4) ? 3'd0 : r_tap + 3'd1;
      if (w_wb) begin
        r_u2[r_sect] <= r_u1[r_sect];
        r_u1[r_sect] <= w_u;
        r_y2[r_sect] <= r_y1[r_sect];
        r_y1[r_sect] <= w_y;
        r_yprev      <= w_y;
        r_sect       <= (r_sect == 3'd5) ? 3'd0 : r_sect + 3'd1;
        if (r_sect == 3'd1) r_out_b <= w_y;
        if (r_sect == 3'd3) r_out_m <= w_y;
        if (r_sect == 3'd5) r_out_a <= w_y;
      end
    end
  end

  assign out_b     = r_out_b;
  assign out_m     = r_out_m;
  assign out_a     = r_out_a;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_biquad_bank_sched.sv
// tb_biquad_bank_sched: directed and random samples checked against
// a plain-arithmetic cascade model of the six biquad sections.
module tb_biquad_bank_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        gen_enable;
  logic        sample_strobe;
  logic [22:0] dato_entrada;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [22:0] coef_data;
  logic [22:0] out_b, out_m, out_a;
  logic        out_valid, busy, overrun;

  biquad_bank_sched dut (
    .clock         (clock),
    .reset         (reset),
    .gen_enable    (gen_enable),
    .sample_strobe (sample_strobe),
    .dato_entrada  (dato_entrada),
    .coef_we       (coef_we),
    .coef_addr     (coef_addr),
    .coef_data     (coef_data),
    .out_b         (out_b),
    .out_m         (out_m),
    .out_a         (out_a),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [22:0] cset [30];
  longint      mc [30];
  longint      mu1 [6], mu2 [6], my1 [6], my2 [6];
  logic [22:0] eb, em, ea;
  logic        eovr;
  logic [22:0] vx [4];
  logic [22:0] vy [4];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic longint sx(input logic [22:0] v);
    return longint'($signed(v));
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 6; s++) begin
      mu1[s] = 0; mu2[s] = 0; my1[s] = 0; my2[s] = 0;
    end
    eb = '0; em = '0; ea = '0; eovr = 1'b0;
  endfunction

  function automatic void model_step(input logic [22:0] x);
    longint u, y, acc;
    u = sx(x);
    for (int s = 0; s < 6; s++) begin
      if (s % 2 == 0) u = sx(x);
      acc = mc[5*s] * u + mc[5*s+1] * mu1[s] + mc[5*s+2] * mu2[s]
          + mc[5*s+3] * my1[s] + mc[5*s+4] * my2[s];
      y = acc >>> 14;
      if (y > 64'sd4194303) y = 64'sd4194303;
      if (y < -64'sd4194304) y = -64'sd4194304;
      mu2[s] = mu1[s]; mu1[s] = u;
      my2[s] = my1[s]; my1[s] = y;
      if (s == 1) eb = y[22:0];
      if (s == 3) em = y[22:0];
      if (s == 5) ea = y[22:0];
      u = y;
    end
  endfunction

  task automatic do_reset;
    reset = 1'b0; sample_strobe = 1'b0; coef_we = 1'b0;
    tick; tick;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wr(input logic [4:0] a, input logic [22:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    tick;
    coef_we = 1'b0;
    if (a < 5'd30) mc[a] = sx(d);
  endtask

  task automatic set_ident;
    for (int i = 0; i < 30; i++) cset[i] = (i % 5 == 0) ? 23'h004000 : 23'h0;
  endtask

  task automatic load_all;
    for (int i = 0; i < 30; i++) wr(5'(i), cset[i]);
  endtask

  // sk: busy strobe, wk: busy write (-2 = write with the start), gk: gen_enable drop
  task automatic run_sample(input logic [22:0] x, input int sk, input int wk,
                            input logic [4:0] wa, input logic [22:0] wd, input int gk);
    int vk, nv;
    if (wk == -2) begin
      coef_we = 1'b1; coef_addr = wa; coef_data = wd;
      if (wa < 5'd30) mc[wa] = sx(wd);
    end
    model_step(x);
    dato_entrada = x; sample_strobe = 1'b1; gen_enable = 1'b1;
    tick;
    sample_strobe = 1'b0;
    chk("busy_start", busy, 1);
    vk = -1; nv = 0;
    for (int k = 0; k < 45; k++) begin
      if (out_valid) begin
        nv++;
        if (vk < 0) vk = k;
      end
      sample_strobe = (k == sk);
      coef_we = (k == wk);
      coef_addr = wa; coef_data = wd;
      if (k == gk) gen_enable = 1'b0;
      if (k == sk) gen_enable = 1'b1;
      tick;
    end
    sample_strobe = 1'b0; coef_we = 1'b0; gen_enable = 1'b1;
    if (sk >= 0) eovr = 1'b1;
    chk("latency", vk, 36);
    chk("n_valid", nv, 1);
    chk("out_b", out_b, eb);
    chk("out_m", out_m, em);
    chk("out_a", out_a, ea);
    chk("overrun", overrun, eovr);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int nv, sk, wk, gk;
    logic [4:0]  wa;
    logic [22:0] wd, x;
    reset = 1'b0; gen_enable = 1'b0; sample_strobe = 1'b0;
    dato_entrada = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    tick; tick;
    chk("rst_out_b", out_b, 0);
    chk("rst_out_m", out_m, 0);
    chk("rst_out_a", out_a, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b1;
    set_ident(); load_all();

    gen_enable = 1'b0; dato_entrada = 23'h001234; sample_strobe = 1'b1;
    tick;
    sample_strobe = 1'b0;
    tick;
    chk("ge_low_busy", busy, 0);
    chk("ge_low_ovr", overrun, 0);

    run_sample(23'h001000, -1, -1, 5'd0, 23'h0, -1);
    chk("ident_b", out_b, 23'h001000);
    chk("ident_m", out_m, 23'h001000);
    chk("ident_a", out_a, 23'h001000);

    gen_enable = 1'b1; dato_entrada = 23'h000777; sample_strobe = 1'b1;
    tick;
    sample_strobe = 1'b0;
    repeat (9) tick;
    sample_strobe = 1'b1;
    tick;
    sample_strobe = 1'b0;
    tick;
    reset = 1'b0; sample_strobe = 1'b1;
    tick;
    sample_strobe = 1'b0;
    tick;
    reset = 1'b1;
    model_reset();
    chk("midrst_b", out_b, 0);
    chk("midrst_m", out_m, 0);
    chk("midrst_a", out_a, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovr", overrun, 0);
    nv = 0;
    repeat (50) begin
      if (out_valid) nv++;
      tick;
    end
    chk("midrst_novalid", nv, 0);

    do_reset(); set_ident();
    cset[1] = 23'h004000; cset[2] = 23'h004000;
    load_all();
    vx[0] = 23'h004000; vx[1] = '0; vx[2] = '0; vx[3] = '0;
    vy[0] = 23'h004000; vy[1] = 23'h004000; vy[2] = 23'h004000; vy[3] = '0;
    for (int i = 0; i < 4; i++) begin
      run_sample(vx[i], -1, -1, 5'd0, 23'h0, -1);
      chk("fir_b", out_b, vy[i]);
    end

    do_reset(); set_ident();
    cset[3] = 23'h002000;
    load_all();
    vy[0] = 23'h004000; vy[1] = 23'h002000; vy[2] = 23'h001000; vy[3] = 23'h000800;
    for (int i = 0; i < 4; i++) begin
      run_sample(vx[i], -1, -1, 5'd0, 23'h0, -1);
      chk("iir_b", out_b, vy[i]);
    end

    do_reset(); set_ident();
    cset[0] = 23'h1FFFFF;
    load_all();
    run_sample(23'h3FFFFF, -1, -1, 5'd0, 23'h0, -1);
    chk("sat_pos_b", out_b, 23'h3FFFFF);
    run_sample(23'h400000, -1, -1, 5'd0, 23'h0, -1);
    chk("sat_neg_b", out_b, 23'h400000);

    do_reset(); set_ident(); load_all();
    run_sample(23'h001000, 9, 4, 5'd0, 23'h008000, -1);
    chk("busy_strobe_ovr", overrun, 1);
    run_sample(23'h002000, -1, -1, 5'd0, 23'h0, -1);
    chk("busy_wr_dropped_b", out_b, 23'h002000);

    do_reset(); set_ident(); load_all();
    run_sample(23'h000100, 36, -1, 5'd0, 23'h0, -1);
    run_sample(23'h000200, -1, -1, 5'd0, 23'h0, 5);
    run_sample(23'h001000, -1, -2, 5'd0, 23'h008000, -1);
    chk("same_cycle_wr_b", out_b, 23'h002000);
    wr(5'd30, 23'h00ABCD);
    wr(5'd31, 23'h001111);
    run_sample(23'h000300, -1, -1, 5'd0, 23'h0, -1);

    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 30; i++) begin
        if (i % 5 < 3)       cset[i] = 23'($urandom_range(0, 32'h4000)) - 23'h002000;
        else if (i % 5 == 3) cset[i] = 23'($urandom_range(0, 32'h5000)) - 23'h002800;
        else                 cset[i] = 23'($urandom_range(0, 32'h2000)) - 23'h001000;
      end
      load_all();
      for (int n = 0; n < 12; n++) begin
        if ($urandom_range(0, 7) == 0) x = 23'($urandom);
        else x = 23'($urandom_range(0, 32'h7FFFF)) - 23'h03FFFF;
        sk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 36)) : -1;
        wk = -1;
        if ($urandom_range(0, 3) == 0) wk = int'($urandom_range(0, 36));
        else if ($urandom_range(0, 5) == 0) wk = -2;
        gk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
        wa = 5'($urandom_range(0, 31));
        wd = 23'($urandom_range(0, 32'h4000)) - 23'h002000;
        run_sample(x, sk, wk, wa, wd, gk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
